// File: rtl/bf_pkg.sv
// Shared constants and state encoding for the bilateral-filter frame sequencer.
package bf_pkg;
   localparam int IMG_W = 256;
   localparam int IMG_H = 256;
   localparam int N_PIX = IMG_W * IMG_H;
   localparam int AW    = 16;
   localparam int DW    = 8;
   localparam int WDOG  = 1900;

   typedef enum logic [2:0] {IDLE, LOAD, DRAIN, OUT, FIN} state_t;
endpackage

// File: rtl/bf_raster_cnt.sv
// Raster position counter: linear address plus row/col, with position flags
// for the current position and a sticky done flag once the last pixel is consumed.
module bf_raster_cnt #(
   parameter int IMG_W = bf_pkg::IMG_W,
   parameter int IMG_H = bf_pkg::IMG_H,
   parameter int AW    = bf_pkg::AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [AW-1:0] addr,
   output logic          sof,
   output logic          eol,
   output logic          last,
   output logic          done
);
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   logic [CW-1:0] col;
   logic [RW-1:0] row;

   assign sof  = (col == '0) && (row == '0);
   assign eol  = (col == CW'(IMG_W - 1));
   assign last = eol && (row == RW'(IMG_H - 1));

   // addr is allowed to wrap when the frame fills the whole address space;
   // done is what tells the frame apart from an empty counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr <= '0;
         col  <= '0;
         row  <= '0;
         done <= 1'b0;
      end else if (clr) begin
         addr <= '0;
         col  <= '0;
         row  <= '0;
         done <= 1'b0;
      end else if (en) begin
         addr <= addr + AW'(1);
         if (last) begin
            col  <= '0;
            row  <= '0;
            done <= 1'b1;
         end else if (eol) begin
            col <= '0;
            row <= row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end
endmodule

// File: rtl/bf_frame_ctrl.sv
// Frame sequencer: raster load into the filter datapath, result collection
// into the result RAM, then a contiguous read-out burst and a finish pulse.
//
// state | meaning
// IDLE  | waiting for first pixel (captured in the same cycle)
// LOAD  | capturing pixels on in_valid, forwarding to datapath
// DRAIN | waiting for all results, bounded by the watchdog
// OUT   | reading result RAM k=0..N-1, then one cycle for the last beat
// FIN   | finish pulse, counters cleared
module bf_frame_ctrl #(
   parameter int IMG_W = bf_pkg::IMG_W,
   parameter int IMG_H = bf_pkg::IMG_H,
   parameter int AW    = bf_pkg::AW,
   parameter int DW    = bf_pkg::DW,
   parameter int WDOG  = bf_pkg::WDOG
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic [AW-1:0] in_addr,
   output logic          out_valid,
   output logic [AW-1:0] out_addr,
   output logic [DW-1:0] out_data,
   output logic          finish,
   output logic          dp_pix_valid,
   output logic [DW-1:0] dp_pix_data,
   output logic          dp_sof,
   output logic          dp_eol,
   output logic          dp_last,
   input  logic          dp_res_valid,
   input  logic [DW-1:0] dp_res_data,
   output logic          rb_we,
   output logic [AW-1:0] rb_waddr,
   output logic [DW-1:0] rb_wdata,
   output logic          rb_re,
   output logic [AW-1:0] rb_raddr,
   input  logic [DW-1:0] rb_rdata,
   output logic          busy,
   output logic          err
);
   import bf_pkg::*;

   localparam int N   = IMG_W * IMG_H;
   localparam int WBW = $clog2(WDOG + 1);

   state_t         state, state_nx;
   logic           capture, ld_sof, ld_eol, ld_last, ld_done;
   logic           res_done, res_drop, out_done, wdog_to, cnt_clr;
   logic [AW-1:0]  res_cnt;
   logic [WBW-1:0] wdog_cnt;
   logic           o_sof_unused, o_eol_unused, o_last_unused;

   assign cnt_clr  = (state == FIN);
   assign capture  = in_valid && !ld_done && ((state == IDLE) || (state == LOAD));
   assign res_drop = dp_res_valid && res_done;
   assign rb_we    = dp_res_valid && !res_done;
   assign rb_waddr = res_cnt;
   assign rb_wdata = rb_we ? dp_res_data : '0;
   assign out_data = out_valid ? rb_rdata : '0;
   assign busy     = (state != IDLE);

   bf_raster_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) u_ld_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .en   (capture),
      .addr (in_addr),
      .sof  (ld_sof),
      .eol  (ld_eol),
      .last (ld_last),
      .done (ld_done)
   );

   bf_raster_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) u_out_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .en   (rb_re),
      .addr (rb_raddr),
      .sof  (o_sof_unused),
      .eol  (o_eol_unused),
      .last (o_last_unused),
      .done (out_done)
   );

   always_comb begin
      state_nx = state;
      rb_re    = 1'b0;
      finish   = 1'b0;
      wdog_to  = 1'b0;
      case (state)
         IDLE:    if (capture) state_nx = ld_last ? DRAIN : LOAD;
         LOAD:    if (capture && ld_last) state_nx = DRAIN;
         DRAIN: begin
            if (res_done) begin
               state_nx = OUT;
            end else if (wdog_cnt == '0) begin
               wdog_to  = 1'b1;
               state_nx = OUT;
            end
         end
         OUT: begin
            rb_re = !out_done;
            if (out_done) state_nx = FIN;
         end
         FIN: begin
            finish   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         res_cnt      <= '0;
         res_done     <= 1'b0;
         wdog_cnt     <= '0;
         err          <= 1'b0;
         dp_pix_valid <= 1'b0;
         dp_pix_data  <= '0;
         dp_sof       <= 1'b0;
         dp_eol       <= 1'b0;
         dp_last      <= 1'b0;
         out_valid    <= 1'b0;
         out_addr     <= '0;
      end else begin
         state        <= state_nx;
         dp_pix_valid <= capture;
         dp_sof       <= capture && ld_sof;
         dp_eol       <= capture && ld_eol;
         dp_last      <= capture && ld_last;
         if (capture) dp_pix_data <= in_data;
         out_valid <= rb_re;
         if (rb_re) out_addr <= rb_raddr;
         if (cnt_clr) begin
            res_cnt  <= '0;
            res_done <= 1'b0;
         end else if (rb_we) begin
            res_cnt <= res_cnt + AW'(1);
            if (res_cnt == AW'(N - 1)) res_done <= 1'b1;
         end
         // watchdog is a down-counter reloaded whenever we are outside DRAIN
         if (state != DRAIN) wdog_cnt <= WBW'(WDOG - 1);
         else if (wdog_cnt != '0) wdog_cnt <= wdog_cnt - WBW'(1);
         if ((state == IDLE) && capture) err <= 1'b0;
         if (wdog_to || res_drop) err <= 1'b1;
      end
   end
endmodule
